// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, fetch FSM states and FIFO entry type.
// Revision    : 1.0
// ============================================================================
package cpu_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 8;
  localparam int DEFAULT_INSTR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEFAULT_ADDR_WIDTH-1:0]  pc;
    logic [DEFAULT_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch entries with a registered head.
// Revision    : 1.0
// ============================================================================
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter type ENTRY_T = fetch_entry_t,
  parameter int  DEPTH   = 4,
  localparam int c_ptr_w = $clog2(DEPTH),
  localparam int c_cnt_w = c_ptr_w + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  ENTRY_T             push_data,
  input  logic               pop,
  input  logic               flush,
  output logic               full,
  output logic               empty,
  output logic [c_cnt_w-1:0] count,
  output ENTRY_T             head
);

  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  ENTRY_T               r_mem [DEPTH];
  ENTRY_T               r_head;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   w_rd_ptr_nxt;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_push;
  logic                 w_pop;

  assign w_push       = push && !flush;
  assign w_pop        = pop && !flush && (r_count != '0);
  assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;

  // Storage needs no reset: it is only read at slots that were written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Head follows the next front entry and holds its last value once empty.
      if (w_push && ((r_count == '0) || (w_pop && (r_count == c_one)))) begin
        r_head <= push_data;
      end else if (w_pop && (r_count > c_one)) begin
        r_head <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  assign full  = (r_count == c_depth);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_head;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch engine with req/ack memory port, PC-tagged FIFO and
//               redirect flush. Optional macro IFU_BYPASS_EN adds an
//               empty-FIFO combinational bypass of the memory response.
// Revision    : 1.0
// ============================================================================
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int DEPTH       = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  output logic                   MemReq,
  output logic [ADDR_WIDTH-1:0]  MemAddr,
  input  logic                   MemAck,
  input  logic [INSTR_WIDTH-1:0] MemData,
  output logic                   InstrValid,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic [ADDR_WIDTH-1:0]  InstrPC,
  input  logic                   InstrReady,
  input  logic                   Redirect,
  input  logic [ADDR_WIDTH-1:0]  RedirectPC
);

  localparam int                 c_cnt_w    = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_depth_m1 = c_cnt_w'(DEPTH - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] w_fetch_pc_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_room;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [c_cnt_w-1:0]    w_fifo_count;
  entry_t                w_push_data;
  entry_t                w_head;

  assign w_pc_inc    = r_fetch_pc + 1'b1;
  assign w_accept    = (r_state == REQ) && MemAck && !Redirect;
  assign w_push_data = {r_fetch_pc, MemData};
  assign w_pop       = InstrReady && !w_fifo_empty && !Redirect;

`ifdef IFU_BYPASS_EN
  logic w_bypass;

  assign w_bypass    = w_fifo_empty && w_accept;
  assign w_push      = w_accept && !(w_bypass && InstrReady);
  assign InstrValid  = !w_fifo_empty || w_bypass;
  assign Instruction = w_bypass ? MemData    : w_head.instr;
  assign InstrPC     = w_bypass ? r_fetch_pc : w_head.pc;
`else
  assign w_push      = w_accept;
  assign InstrValid  = !w_fifo_empty;
  assign Instruction = w_head.instr;
  assign InstrPC     = w_head.pc;
`endif

  // Occupancy after this cycle's push/pop is still below DEPTH.
  assign w_room = (w_fifo_count < c_depth_m1) || w_pop;

  fetch_fifo #(
    .ENTRY_T (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (Redirect),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count),
    .head      (w_head)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_fetch_pc <= '0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_mem_addr_nxt = r_mem_addr;
    case (r_state)
      IDLE: begin
        if (Redirect) begin
          w_fetch_pc_nxt = RedirectPC;
        end else if (!w_fifo_full) begin
          w_state_nxt    = REQ;
          w_mem_addr_nxt = r_fetch_pc;
        end
      end
      REQ: begin
        if (Redirect) begin
          w_fetch_pc_nxt = RedirectPC;
          w_state_nxt    = MemAck ? IDLE : DRAIN;
        end else if (MemAck) begin
          w_fetch_pc_nxt = w_pc_inc;
          if (w_room) begin
            w_mem_addr_nxt = w_pc_inc;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        // The stale request must complete before a new one can be issued.
        if (Redirect) begin
          w_fetch_pc_nxt = RedirectPC;
        end
        if (MemAck) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign MemReq  = (r_state != IDLE);
  assign MemAddr = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit.
// Revision    : 1.0
// ============================================================================
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MemReq;
  logic [7:0]  MemAddr;
  logic        MemAck;
  logic [15:0] MemData;
  logic        InstrValid;
  logic [15:0] Instruction;
  logic [7:0]  InstrPC;
  logic        InstrReady;
  logic        Redirect;
  logic [7:0]  RedirectPC;

  logic        wait_mode;
  logic [1:0]  wcnt;
  int          n_vec = 0;
  int          n_err = 0;

  instruction_fetch_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .MemReq      (MemReq),
    .MemAddr     (MemAddr),
    .MemAck      (MemAck),
    .MemData     (MemData),
    .InstrValid  (InstrValid),
    .Instruction (Instruction),
    .InstrPC     (InstrPC),
    .InstrReady  (InstrReady),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC)
  );

  always #5 CLK = ~CLK;

  // Memory model: word n holds 0x1000+n; ack is constant or the 4th cycle of a request.
  assign MemData = 16'h1000 + {8'h00, MemAddr};
  assign MemAck  = wait_mode ? (MemReq && (wcnt == 2'd3)) : 1'b1;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET)                 wcnt <= 2'd0;
    else if (MemReq && !MemAck) wcnt <= wcnt + 2'd1;
    else                        wcnt <= 2'd0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_pc;
    logic [7:0] old_addr;
    logic       prev_req;
    logic       prev_ack;
    logic [7:0] prev_addr;

    RESET      = 1'b0;
    InstrReady = 1'b1;
    Redirect   = 1'b0;
    RedirectPC = 8'h00;
    wait_mode  = 1'b0;

    // Reset state (MemAck already high: must be ignored)
    #12;
    check("rst_memreq",  MemReq,      0);
    check("rst_memaddr", MemAddr,     0);
    check("rst_valid",   InstrValid,  0);
    check("rst_instr",   Instruction, 0);
    check("rst_pc",      InstrPC,     0);

    // Zero-wait fetch
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    check("zw_req1",   MemReq,     1);
    check("zw_addr1",  MemAddr,    0);
    check("zw_valid1", InstrValid, 0);
    tick();
    check("zw_valid2", InstrValid, 1);
    for (int n = 0; n < 5; n++) begin
      check("zw_pc",    InstrPC,     n);
      check("zw_instr", Instruction, 32'h1000 + n);
      tick();
    end

    // Backpressure: four entries, then request stops
    InstrReady = 1'b0;
    apply_reset();
    for (int n = 0; n < 5; n++) tick();
    check("bp_stop",  MemReq,     0);
    check("bp_valid", InstrValid, 1);
    check("bp_pc0",   InstrPC,    0);
    tick();
    check("bp_still", MemReq, 0);
    InstrReady = 1'b1;
    tick();
    check("bp_pc1",   InstrPC, 1);
    check("bp_req7",  MemReq,  0);
    tick();
    check("bp_pc2",   InstrPC, 2);
    check("bp_req8",  MemReq,  1);
    check("bp_addr8", MemAddr, 4);
    tick();
    check("bp_pc3",   InstrPC, 3);
    tick();
    check("bp_pc4",   InstrPC, 4);
    check("bp_ins4",  Instruction, 16'h1004);

    // Wait-state memory
    wait_mode = 1'b1;
    apply_reset();
    exp_pc    = 8'h00;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (prev_req && !prev_ack) check("ws_addr_stable", MemAddr, prev_addr);
      if (InstrValid && InstrReady) begin
        check("ws_pc",    InstrPC,     exp_pc);
        check("ws_instr", Instruction, 16'h1000 + {8'h00, exp_pc});
        exp_pc = exp_pc + 8'd1;
      end
      prev_req  = MemReq;
      prev_ack  = MemAck;
      prev_addr = MemAddr;
      tick();
    end
    check("ws_count", exp_pc, 4);

    // Redirect while a request is outstanding
    for (int k = 0; k < 10 && !(MemReq && !MemAck); k++) tick();
    check("rd_pre", MemReq && !MemAck, 1);
    old_addr   = MemAddr;
    Redirect   = 1'b1;
    RedirectPC = 8'h40;
    tick();
    Redirect = 1'b0;
    check("rd_flush",     InstrValid, 0);
    check("rd_hold_req",  MemReq,     1);
    check("rd_hold_addr", MemAddr,    old_addr);
    for (int k = 0; k < 10 && MemReq; k++) tick();
    check("rd_drained", MemReq,     0);
    check("rd_dropped", InstrValid, 0);
    for (int k = 0; k < 10 && !MemReq; k++) tick();
    check("rd_newreq",  MemReq,  1);
    check("rd_newaddr", MemAddr, 8'h40);
    for (int k = 0; k < 10 && !InstrValid; k++) tick();
    check("rd_valid", InstrValid,  1);
    check("rd_pc",    InstrPC,     8'h40);
    check("rd_instr", Instruction, 16'h1040);

    // PC wrap-around
    wait_mode  = 1'b0;
    Redirect   = 1'b1;
    RedirectPC = 8'hFE;
    tick();
    Redirect = 1'b0;
    for (int k = 0; k < 10 && !InstrValid; k++) tick();
    exp_pc = 8'hFE;
    for (int n = 0; n < 4; n++) begin
      check("wr_valid", InstrValid,  1);
      check("wr_pc",    InstrPC,     exp_pc);
      check("wr_instr", Instruction, 16'h1000 + {8'h00, exp_pc});
      exp_pc = exp_pc + 8'd1;
      tick();
    end

    // Asynchronous reset mid-operation
    InstrReady = 1'b0;
    tick();
    check("ar_pre_valid", InstrValid, 1);
    #2;
    RESET = 1'b0;
    #1;
    check("ar_memreq",  MemReq,      0);
    check("ar_memaddr", MemAddr,     0);
    check("ar_valid",   InstrValid,  0);
    check("ar_instr",   Instruction, 0);
    check("ar_pc",      InstrPC,     0);
    @(negedge CLK);
    RESET      = 1'b1;
    InstrReady = 1'b1;
    tick();
    check("ar_req1",  MemReq,  1);
    check("ar_addr1", MemAddr, 0);
    tick();
    check("ar_valid2", InstrValid,  1);
    check("ar_pc2",    InstrPC,     0);
    check("ar_instr2", Instruction, 16'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream stage of the single-cycle core.
- Replaces the bare PC register and +1 adder with a fetch engine that talks to a variable-latency instruction memory over a req/ack handshake.
- Buffers fetched 16-bit instructions, each tagged with its PC, in a small FIFO.
- Presents them to decode/execute through a valid/ready interface and supports a redirect (jump/branch) input that flushes all fetched-but-unconsumed work.

Parameters:
- ADDR_WIDTH, 8, PC and instruction-memory address width.
- INSTR_WIDTH, 16, instruction word width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset (0 = in reset).
- MemReq  output  1  fetch request to instruction memory.
- MemAddr  output  ADDR_WIDTH  fetch address; valid while MemReq=1.
- MemAck  input  1  memory has ReadData valid for the current MemAddr.
- MemData  input  INSTR_WIDTH  instruction word; sampled when MemReq&&MemAck.
- InstrValid  output  1  FIFO head is valid.
- Instruction  output  INSTR_WIDTH  FIFO head instruction.
- InstrPC  output  ADDR_WIDTH  PC of the FIFO head.
- InstrReady  input  1  consumer accepts the head this cycle.
- Redirect  input  1  flush and restart fetch at RedirectPC.
- RedirectPC  input  ADDR_WIDTH  new fetch PC; sampled when Redirect=1.

Behaviour:
- **Reset (RESET=0, async):**
  - FetchPC=0, state=IDLE, FIFO empty.
  - MemReq=0, MemAddr=0, InstrValid=0, Instruction=0, InstrPC=0.
  - Reset asserted mid-handshake abandons the outstanding request; memory must tolerate this.
- **FSM states:** IDLE, REQ, DRAIN.
- **IDLE:**
  - If count<DEPTH and no Redirect: next edge sets MemReq=1, MemAddr=FetchPC, goes to REQ.
  - If Redirect=1: FetchPC<=RedirectPC, stay IDLE.
- **REQ:**
  - MemReq and MemAddr stay stable until an edge samples MemAck=1.
  - On that edge: push {FetchPC, MemData}, FetchPC<=FetchPC+1.
  - If count after push/pop is <DEPTH, issue the next request back-to-back (MemReq stays 1, MemAddr=new FetchPC, remain REQ); otherwise MemReq<=0 and go to IDLE.
- **DRAIN:**
  - MemReq held at 1 (a handshake is never abandoned).
  - When MemAck=1: data discarded, MemReq<=0, go to IDLE.
  - FetchPC already holds the redirect target.
- **Redirect priority:** Redirect beats both push and pop in the same cycle.
  - FIFO count<=0 and FetchPC<=RedirectPC.
  - In REQ with MemAck=0: go to DRAIN.
  - In REQ with MemAck=1: the returned word is discarded, go to IDLE.
  - In DRAIN: a further redirect just updates FetchPC.
- **At most one outstanding memory request.** Requests are issued only when count<DEPTH, so a push never overflows.
- **Pop:** when InstrValid&&InstrReady, and not on a Redirect cycle. Push and pop in the same cycle leave count unchanged, including when full.
- **Outputs:**
  - InstrValid=(count!=0).
  - Instruction/InstrPC are the registered FIFO head; they hold their value when empty.
- **Latency:**
  - Zero-wait memory (MemAck tied 1): first MemReq on the 1st edge after RESET rises; InstrValid=1 after the 2nd edge.
  - Sustained throughput is 1 instr/cycle.
- **Arithmetic:** FetchPC increments modulo 2^ADDR_WIDTH (0xFF -> 0x00, no flag). FIFO pointers wrap modulo DEPTH.
- **Illegal input:** MemAck while MemReq=0 is ignored.

Optional Feature:
- Macro: IFU_BYPASS_EN.
- When defined: if the FIFO is empty and an accepted memory response arrives, MemData/FetchPC drive Instruction/InstrPC combinationally with InstrValid=1 in the same cycle. If InstrReady=1 that cycle, the word is consumed without being written to the FIFO. First-instruction latency drops by one cycle.
- When undefined: all outputs are registered as described above.

Decomposition:
- **Package cpu_pkg:**
  - ADDR_WIDTH/INSTR_WIDTH defaults.
  - fetch_state_t enum {IDLE, REQ, DRAIN}.
  - fetch_entry_t struct {pc, instr}.
- **Sub-module fetch_fifo:**
  - Parameterised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, count, head.
  - Asynchronous active-low reset.

Test Plan:
- **Reset then zero-wait fetch:** MemAck=1, InstrReady=1, memory[n]=0x1000+n. Expect InstrPC sequence 0x00,0x01,0x02… with Instruction 0x1000,0x1001…; InstrValid=1 from the 2nd edge after reset release.
- **Backpressure:** InstrReady=0, zero-wait memory. Expect exactly DEPTH=4 entries (PCs 0–3), then MemReq=0. Raising InstrReady drains PCs 0–3 in order and fetch resumes at PC 4.
- **Wait-state memory:** MemAck asserted 3 cycles after each MemReq. MemAddr must stay stable throughout; one push per ack; no duplicate or skipped PCs.
- **Redirect during outstanding request:** Redirect with RedirectPC=0x40 while in REQ with MemAck=0. Expect FIFO empty next cycle, MemReq held until ack, that data dropped, then next fetch MemAddr=0x40.
- **Wrap-around:** Redirect to 0xFE, zero-wait memory. Expect InstrPC 0xFE,0xFF,0x00,0x01.
- **Async reset mid-operation:** RESET low between clock edges with the FIFO half full. Expect outputs zero immediately with no clock; after release, fetch restarts at 0x00.
